// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, lock-loss
// counter width and the hold-counter width helper.
package reset_seq_pkg;

    localparam int STATE_W     = 3;
    localparam int LOCK_LOSS_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_WAIT_GBT  = 3'd1,
        ST_TRIG_HOLD = 3'd2,
        ST_RUN       = 3'd3,
        ST_SOFT      = 3'd4
    } state_e;

    // The counter only ever holds (param - 1), so clog2 of the largest
    // parameter is enough; keep at least one bit when every parameter is 1.
    function automatic int hold_cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/stable_counter.sv
// Consecutive-cycle qualifier: counts enabled cycles, drops to zero when the
// enable falls or on clear, and flags the cycle it sits at the terminal count.
module stable_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] threshold_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // threshold_i is the terminal count (hold length - 1), so a hold of one
    // cycle completes on the first enabled cycle.
    assign done_o = enable_i && (count_q == threshold_i);

    always_comb begin
        count_d = count_q;
        if (clear_i || !enable_i) begin
            count_d = '0;
        end else if (count_q != threshold_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Power-up / link reset sequencer: holds core and trigger resets until the
// MMCMs lock and the GBT link is stable, with soft-reset and lock-loss handling.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int CORE_HOLD    = 1024,
    parameter int GBT_STABLE   = 64,
    parameter int TRIG_HOLD    = 256,
    parameter int SOFT_HOLD    = 16,
    parameter int TMR_INSTANCE = 0
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   soft_reset_i,
    input  logic                   mmcms_locked_i,
    input  logic                   gbt_rxready_i,
    input  logic                   gbt_rxvalid_i,
    input  logic                   gbt_txready_i,
    output logic                   core_reset_o,
    output logic                   trigger_reset_o,
    output logic                   ready_o,
    output logic [STATE_W-1:0]     state_o,
    output logic [LOCK_LOSS_W-1:0] lock_loss_cnt_o
);

    localparam int CNT_W = hold_cnt_width(CORE_HOLD, GBT_STABLE, TRIG_HOLD, SOFT_HOLD);

    localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_HOLD - 1);
    localparam logic [CNT_W-1:0] GBT_LAST  = CNT_W'(GBT_STABLE - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_HOLD - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_HOLD - 1);

    // TMR_INSTANCE only distinguishes replicas for the voting wrapper; it
    // carries no function, so the block below is deliberately empty.
    if (TMR_INSTANCE < 0) begin : g_tmr_instance_unused
    end

    state_e                   state_q;
    state_e                   state_d;
    logic [LOCK_LOSS_W-1:0]   lock_loss_q;
    logic [LOCK_LOSS_W-1:0]   lock_loss_d;

    logic                     gbt_ok;
    logic                     cnt_enable;
    logic                     cnt_clear;
    logic                     cnt_restart;
    logic                     cnt_done;
    logic                     lock_lost;
    logic [CNT_W-1:0]         cnt_threshold;

    assign gbt_ok = gbt_rxready_i && gbt_rxvalid_i && gbt_txready_i;

    stable_counter #(
        .WIDTH (CNT_W)
    ) u_stable_counter (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .enable_i    (cnt_enable),
        .clear_i     (cnt_clear),
        .threshold_i (cnt_threshold),
        .done_o      (cnt_done)
    );

    always_comb begin
        state_d       = state_q;
        cnt_enable    = 1'b0;
        cnt_threshold = '0;
        cnt_restart   = 1'b0;
        lock_lost     = 1'b0;

        case (state_q)
            ST_WAIT_LOCK: begin
                cnt_enable    = mmcms_locked_i;
                cnt_threshold = CORE_LAST;
            end
            ST_WAIT_GBT: begin
                cnt_enable    = gbt_ok;
                cnt_threshold = GBT_LAST;
            end
            ST_TRIG_HOLD: begin
                cnt_enable    = 1'b1;
                cnt_threshold = TRIG_LAST;
            end
            ST_SOFT: begin
                cnt_enable    = 1'b1;
                cnt_threshold = SOFT_LAST;
            end
            default: begin
                cnt_enable    = 1'b0;
                cnt_threshold = '0;
            end
        endcase

        // Event priority: lock loss, soft reset, GBT loss, count completion.
        if (state_q == ST_WAIT_LOCK) begin
            if (cnt_done) begin
                state_d = ST_WAIT_GBT;
            end
        end else if (!mmcms_locked_i) begin
            state_d   = ST_WAIT_LOCK;
            lock_lost = 1'b1;
        end else if (soft_reset_i) begin
            state_d     = ST_SOFT;
            cnt_restart = (state_q == ST_SOFT);
        end else if (!gbt_ok && (state_q == ST_TRIG_HOLD || state_q == ST_RUN)) begin
            state_d = ST_WAIT_GBT;
        end else if (cnt_done) begin
            case (state_q)
                ST_WAIT_GBT:  state_d = ST_TRIG_HOLD;
                ST_TRIG_HOLD: state_d = ST_RUN;
                ST_SOFT:      state_d = ST_WAIT_GBT;
                default:      state_d = state_q;
            endcase
        end

        cnt_clear = (state_d != state_q) || cnt_restart;
    end

    always_comb begin
        lock_loss_d = lock_loss_q;
        if (lock_lost && (lock_loss_q != {LOCK_LOSS_W{1'b1}})) begin
            lock_loss_d = lock_loss_q + LOCK_LOSS_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_WAIT_LOCK;
            lock_loss_q <= '0;
        end else begin
            state_q     <= state_d;
            lock_loss_q <= lock_loss_d;
        end
    end

    always_comb begin
        core_reset_o    = 1'b0;
        trigger_reset_o = 1'b1;
        ready_o         = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: core_reset_o = 1'b1;
            ST_RUN: begin
                trigger_reset_o = 1'b0;
                ready_o         = 1'b1;
            end
            default: begin
                core_reset_o    = 1'b0;
                trigger_reset_o = 1'b1;
            end
        endcase
    end

    assign state_o         = state_q;
    assign lock_loss_cnt_o = lock_loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues every expected output change with the
// edge it must occur on; a negedge monitor pops and compares on each change.
module tb_reset_sequencer;

    logic       clk;
    logic       reset_i;
    logic       soft_reset_i;
    logic       mmcms_locked_i;
    logic       gbt_rxready_i;
    logic       gbt_rxvalid_i;
    logic       gbt_txready_i;
    logic       core_reset_o;
    logic       trigger_reset_o;
    logic       ready_o;
    logic [2:0] state_o;
    logic [7:0] lock_loss_cnt_o;

    reset_sequencer #(
        .CORE_HOLD    (8),
        .GBT_STABLE   (4),
        .TRIG_HOLD    (6),
        .SOFT_HOLD    (3),
        .TMR_INSTANCE (0)
    ) dut (
        .clock_i         (clk),
        .reset_i         (reset_i),
        .soft_reset_i    (soft_reset_i),
        .mmcms_locked_i  (mmcms_locked_i),
        .gbt_rxready_i   (gbt_rxready_i),
        .gbt_rxvalid_i   (gbt_rxvalid_i),
        .gbt_txready_i   (gbt_txready_i),
        .core_reset_o    (core_reset_o),
        .trigger_reset_o (trigger_reset_o),
        .ready_o         (ready_o),
        .state_o         (state_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    typedef struct {
        int          edge_no;
        logic [13:0] val;
    } exp_t;

    localparam logic [2:0] S_WL = 3'd0;
    localparam logic [2:0] S_WG = 3'd1;
    localparam logic [2:0] S_TH = 3'd2;
    localparam logic [2:0] S_RN = 3'd3;
    localparam logic [2:0] S_SF = 3'd4;

    exp_t        exp_q[$];
    exp_t        exp_e;
    int          edge_cnt = 0;
    int          checks   = 0;
    int          failures = 0;
    logic [13:0] obs;
    logic [13:0] prev_obs = 14'h3fff;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Output tuple: {core, trig, ready, state[2:0], lock_loss[7:0]}
    function automatic logic [13:0] mk(input logic c, input logic t, input logic r,
                                       input logic [2:0] st, input logic [7:0] llc);
        return {c, t, r, st, llc};
    endfunction

    task automatic push(input int ed, input logic [2:0] st, input logic [7:0] llc);
        exp_t x;
        logic c, t, r;
        c = (st == S_WL);
        t = (st != S_RN);
        r = (st == S_RN);
        x.edge_no = ed;
        x.val     = mk(c, t, r, st, llc);
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int e);
        while (edge_cnt < e) tick();
    endtask

    always @(negedge clk) begin
        obs = {core_reset_o, trigger_reset_o, ready_o, state_o, lock_loss_cnt_o};
        if (!$isunknown(obs) && obs != prev_obs) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change edge=%0d got=%h required=none", edge_cnt, obs);
            end else begin
                exp_e = exp_q.pop_front();
                if (exp_e.edge_no != edge_cnt || exp_e.val != obs) begin
                    failures++;
                    $display("FAIL output_change edge=%0d got=%h required edge=%0d val=%h",
                             edge_cnt, obs, exp_e.edge_no, exp_e.val);
                end else begin
                    $display("ok edge=%0d core=%0b trig=%0b ready=%0b state=%0d llc=%0d",
                             edge_cnt, obs[13], obs[12], obs[11], obs[10:8], obs[7:0]);
                end
            end
            prev_obs = obs;
        end
    end

    initial begin
        int t;
        int e;
        int r;
        logic [7:0] lc;

        reset_i        = 1'b1;
        soft_reset_i   = 1'b0;
        mmcms_locked_i = 1'b0;
        gbt_rxready_i  = 1'b0;
        gbt_rxvalid_i  = 1'b0;
        gbt_txready_i  = 1'b0;

        // Reset state appears after the first edge.
        push(1, S_WL, 8'd0);
        tick_to(2);

        // Lock glitch while waiting for lock: count restarts, no lock-loss count.
        reset_i        = 1'b0;
        mmcms_locked_i = 1'b1;
        gbt_rxready_i  = 1'b1;
        gbt_rxvalid_i  = 1'b1;
        gbt_txready_i  = 1'b1;
        push(15, S_WG, 8'd0);
        push(19, S_TH, 8'd0);
        push(25, S_RN, 8'd0);
        tick_to(6);
        mmcms_locked_i = 1'b0;
        tick_to(7);
        mmcms_locked_i = 1'b1;
        tick_to(27);

        // Soft reset in RUN: 3 SOFT + 4 WAIT_GBT + 6 TRIG_HOLD, core stays low.
        soft_reset_i = 1'b1;
        push(28, S_SF, 8'd0);
        push(31, S_WG, 8'd0);
        push(35, S_TH, 8'd0);
        push(41, S_RN, 8'd0);
        tick();
        soft_reset_i = 1'b0;
        tick_to(43);

        // Lock loss together with soft reset: lock loss wins.
        mmcms_locked_i = 1'b0;
        soft_reset_i   = 1'b1;
        push(44, S_WL, 8'd1);
        push(52, S_WG, 8'd1);
        push(56, S_TH, 8'd1);
        push(62, S_RN, 8'd1);
        tick();
        soft_reset_i   = 1'b0;
        mmcms_locked_i = 1'b1;
        tick_to(64);

        // One-cycle GBT drop in RUN.
        gbt_rxvalid_i = 1'b0;
        push(65, S_WG, 8'd1);
        push(69, S_TH, 8'd1);
        push(75, S_RN, 8'd1);
        tick();
        gbt_rxvalid_i = 1'b1;
        tick_to(77);

        // Park in WAIT_GBT with the link down, then drive lock losses to saturation.
        gbt_rxready_i = 1'b0;
        push(78, S_WG, 8'd1);
        tick_to(80);
        for (int n = 2; n <= 260; n++) begin
            e  = edge_cnt;
            lc = (n > 255) ? 8'd255 : 8'(n);
            mmcms_locked_i = 1'b0;
            push(e + 1, S_WL, lc);
            push(e + 9, S_WG, lc);
            tick();
            mmcms_locked_i = 1'b1;
            tick_to(e + 9);
        end

        // Reset in the middle of TRIG_HOLD, then the full power-up sequence.
        t = edge_cnt;
        gbt_rxready_i = 1'b1;
        push(t + 4, S_TH, 8'd255);
        push(t + 7, S_WL, 8'd0);
        tick_to(t + 6);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        r = edge_cnt;
        push(r + 8, S_WG, 8'd0);
        push(r + 12, S_TH, 8'd0);
        push(r + 18, S_RN, 8'd0);
        tick_to(r + 22);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_changes pending=%0d required=0 next_edge=%0d",
                     exp_q.size(), exp_q[0].edge_no);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter CORE_HOLD, default 1024, meaning consecutive mmcms-locked cycles required before core reset release.
REQ-002 Parameter GBT_STABLE, default 64, meaning consecutive cycles with all GBT status high before trigger hold starts.
REQ-003 Parameter TRIG_HOLD, default 256, meaning cycles trigger reset is held after GBT is stable.
REQ-004 Parameter SOFT_HOLD, default 16, meaning trigger-reset hold cycles after a soft reset request.
REQ-005 clock_i  in  1  sole clock; all logic is in this domain.
REQ-006 reset_i  in  1  synchronous, active-high reset.
REQ-007 soft_reset_i  in  1  single-cycle soft reset request.
REQ-008 mmcms_locked_i  in  1  MMCM lock status.
REQ-009 gbt_rxready_i, gbt_rxvalid_i, gbt_txready_i  in  1 each  GBT link status.
REQ-010 core_reset_o  out  1  core-logic reset, active high.
REQ-011 trigger_reset_o  out  1  trigger-path reset, active high.
REQ-012 ready_o  out  1  high only in RUN.
REQ-013 state_o  out  3  current FSM state encoding.
REQ-014 lock_loss_cnt_o  out  8  saturating count of MMCM lock losses.

Function
REQ-015 States SHALL be WAIT_LOCK, WAIT_GBT, TRIG_HOLD, RUN, SOFT; all outputs are Moore decodes of the registered state, with no combinational path from inputs to outputs.
REQ-016 Outputs per state: WAIT_LOCK core=1 trig=1; WAIT_GBT, TRIG_HOLD and SOFT core=0 trig=1; RUN core=0 trig=0 ready=1.
REQ-017 WAIT_LOCK: a single counter increments on each cycle with mmcms_locked_i=1 and clears on 0; on the cycle it reaches CORE_HOLD-1 with lock still high, the FSM goes to WAIT_GBT. With lock high from edge k, core_reset_o falls at edge k+CORE_HOLD.
REQ-018 WAIT_GBT: counter increments while all three GBT inputs are high and clears otherwise; reaching GBT_STABLE-1 goes to TRIG_HOLD.
REQ-019 TRIG_HOLD: counter increments unconditionally; reaching TRIG_HOLD-1 goes to RUN.
REQ-020 SOFT: counter increments unconditionally; reaching SOFT_HOLD-1 goes to WAIT_GBT.
REQ-021 Any GBT input low in TRIG_HOLD or RUN SHALL go to WAIT_GBT on the next edge.
REQ-022 soft_reset_i=1 in WAIT_GBT, TRIG_HOLD or RUN SHALL go to SOFT; in SOFT it restarts the SOFT count; in WAIT_LOCK it is ignored.
REQ-023 mmcms_locked_i=0 in any state other than WAIT_LOCK SHALL go to WAIT_LOCK and increment lock_loss_cnt_o, saturating at 255.
REQ-024 Priority, when events coincide: lock loss > soft reset > GBT loss > count completion.
REQ-025 The counter SHALL clear on every state change; its width is clog2 of the largest parameter, and it never wraps.
REQ-026 Parameters SHALL be at least 1; a value of 1 means the state lasts exactly one cycle.

Reset
REQ-027 reset_i=1 SHALL force WAIT_LOCK, counter=0, lock_loss_cnt_o=0, core_reset_o=1, trigger_reset_o=1, ready_o=0, state_o=WAIT_LOCK's encoding on the next edge, regardless of other inputs.
REQ-028 Reset asserted mid-sequence SHALL abort the sequence immediately; no partial hold carries over.

Structure
REQ-029 State encoding (WAIT_LOCK=0, WAIT_GBT=1, TRIG_HOLD=2, RUN=3, SOFT=4) and the lock-loss counter width SHALL live in a shared package, reset_seq_pkg.
REQ-030 Consecutive-cycle qualification SHALL be one sub-module, stable_counter (enable, clear, threshold, done), instantiated once.
REQ-031 The block SHALL carry a TMR_INSTANCE parameter (default 0, functionally unused) so it can be triplicated and majority-voted by the existing TMR wrapper scheme.

Verification (CORE_HOLD=8, GBT_STABLE=4, TRIG_HOLD=6, SOFT_HOLD=3)
REQ-032 Reset, then lock high from edge 0 and GBT high -> core_reset_o falls at edge 8, trigger_reset_o falls at edge 18, ready_o rises at edge 18.
REQ-033 Lock glitches low for one cycle at edge 5 during WAIT_LOCK -> the count restarts, core_reset_o falls 8 cycles after lock returns, lock_loss_cnt_o stays 0.
REQ-034 soft_reset_i pulse in RUN -> trigger_reset_o high for 3 cycles in SOFT, then 4 in WAIT_GBT and 6 in TRIG_HOLD; core_reset_o stays 0 throughout.
REQ-035 Lock loss coinciding with soft_reset_i in RUN -> next state is WAIT_LOCK, core_reset_o=1, lock_loss_cnt_o increments by 1.
REQ-036 Drive 260 lock losses -> lock_loss_cnt_o saturates at 255; reset_i mid-TRIG_HOLD -> all outputs return to their reset values on the next edge.
